// File: rtl/alu_execute.sv
// alu_execute: MIPS execute stage with single-cycle ALU/shifts and a 32-iteration multiply/divide engine.
module alu_execute #(
  parameter int WIDTH = 32,
  parameter int ITER = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [3:0]       ALU_control,
  input  logic             ALUSrc,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] sign_ext_imm,
  input  logic [4:0]       shamt,
  output logic             ready,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero,
  output logic [WIDTH-1:0] write_data
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a, b, diff, res, ma, mb;
  logic [WIDTH-1:0] hi, lo, acc, q, m, orig;
  logic [WIDTH-1:0] nacc, nq, dacc, dq, qf, rf;
  logic [2*WIDTH-1:0] prod, pf;
  logic [WIDTH:0] sum, rsh, trial;
  logic [5:0] cnt;
  logic accept, op_mul, op_div, sa, sb, neg_q, neg_r, div0, last, ok;
  assign a = read_data1;
  assign b = ALUSrc ? sign_ext_imm : read_data2;
  assign diff = a - b;
  assign busy = state != IDLE;
  assign ready = !busy;
  assign accept = valid_in && ready;
  assign op_mul = ALU_control[3:1] == 3'b100;
  assign op_div = ALU_control[3:1] == 3'b101;
  assign sa = !ALU_control[0] && a[WIDTH-1];
  assign sb = !ALU_control[0] && b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign last = cnt == 6'(ITER-1);
  // Shift-add multiply: acc holds the running high half, q shifts the multiplier out and product bits in.
  assign sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
  assign nacc = sum[WIDTH:1];
  assign nq = {sum[0], q[WIDTH-1:1]};
  assign prod = {nacc, nq};
  assign pf = neg_q ? -prod : prod;
  // Restoring divide: acc is the partial remainder, q shifts the dividend out and quotient bits in.
  assign rsh = {acc, q[WIDTH-1]};
  assign trial = rsh - {1'b0, m};
  assign ok = !trial[WIDTH];
  assign dacc = ok ? trial[WIDTH-1:0] : rsh[WIDTH-1:0];
  assign dq = {q[WIDTH-2:0], ok};
  assign qf = neg_q ? -dq : dq;
  assign rf = neg_r ? -dacc : dacc;
  always_comb begin
    res = '0;
    case (ALU_control)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: res = a + b;
      4'b0011: res = a ^ b;
      4'b0110: res = diff;
      4'b0111: res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1100: res = ~(a | b);
      4'b0100: res = b << shamt;
      4'b0101: res = b >> shamt;
      4'b1111: res = $signed(b) >>> shamt;
      4'b1101: res = hi;
      4'b1110: res = lo;
      default: res = '0;
    endcase
  end
  always_comb begin
    nxt = state;
    nxt = (state == IDLE) ? (accept && op_mul ? MUL : accept && op_div ? DIV : IDLE)
                          : (last ? IDLE : state);
  end
  always_ff @(posedge clock) state <= reset ? IDLE : nxt;
  always_ff @(posedge clock) begin
    if (reset) begin
      ALU_result <= '0;
      write_data <= '0;
      zero <= 1'b0;
      valid_out <= 1'b0;
      hi <= '0;
      lo <= '0;
      acc <= '0;
      q <= '0;
      m <= '0;
      orig <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      cnt <= '0;
    end else begin
      valid_out <= accept;
      if (accept) begin
        ALU_result <= res;
        zero <= diff == '0;
        write_data <= read_data2;
      end
      if (accept && (op_mul || op_div)) begin
        acc <= '0;
        q <= ma;
        m <= mb;
        orig <= a;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        div0 <= b == '0;
        cnt <= '0;
      end else if (state == MUL) begin
        acc <= nacc;
        q <= nq;
        cnt <= cnt + 6'd1;
        if (last) {hi, lo} <= pf;
      end else if (state == DIV) begin
        acc <= dacc;
        q <= dq;
        cnt <= cnt + 6'd1;
        if (last) begin
          hi <= div0 ? orig : rf;
          lo <= div0 ? '1 : qf;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_execute.sv
// tb_alu_execute: directed checks of ALU ops, multiply/divide timing and results, stalls and reset.
module tb_alu_execute;
  logic clock = 0, reset = 1, valid_in = 0, ALUSrc = 0;
  logic [3:0] ALU_control = 0;
  logic [31:0] read_data1 = 0, read_data2 = 0, sign_ext_imm = 0;
  logic [4:0] shamt = 0;
  logic ready, busy, valid_out, zero;
  logic [31:0] ALU_result, write_data;
  int n_chk = 0, n_fail = 0, n;

  alu_execute dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ALU_control(ALU_control),
    .ALUSrc(ALUSrc), .read_data1(read_data1), .read_data2(read_data2),
    .sign_ext_imm(sign_ext_imm), .shamt(shamt), .ready(ready), .busy(busy),
    .valid_out(valid_out), .ALU_result(ALU_result), .zero(zero), .write_data(write_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic [3:0] c, input logic src, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] imm, input logic [4:0] sh);
    ALU_control = c; ALUSrc = src; read_data1 = x; read_data2 = y; sign_ext_imm = imm; shamt = sh;
    valid_in = 1;
    tick();
    valid_in = 0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    tick(); tick();
    chk("rst_result", ALU_result, 0);
    chk("rst_valid", {31'b0, valid_out}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ready", {31'b0, ready}, 1);
    chk("rst_zero", {31'b0, zero}, 0);
    chk("rst_wdata", write_data, 0);
    reset = 0;
    tick();

    op(4'b0010, 0, 32'h7FFFFFFF, 32'h1, 0, 0);
    chk("add_result", ALU_result, 32'h80000000);
    chk("add_valid", {31'b0, valid_out}, 1);
    chk("add_zero", {31'b0, zero}, 0);
    tick();
    chk("idle_valid", {31'b0, valid_out}, 0);
    chk("idle_hold", ALU_result, 32'h80000000);

    op(4'b0110, 1, 32'd5, 32'h1234, 32'd5, 0);
    chk("sub_result", ALU_result, 0);
    chk("sub_zero", {31'b0, zero}, 1);
    chk("sub_wdata", write_data, 32'h1234);

    op(4'b0000, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0);
    chk("and", ALU_result, 32'h00F000F0);
    op(4'b0001, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0);
    chk("or", ALU_result, 32'hFFF0FFF0);
    op(4'b0011, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0);
    chk("xor", ALU_result, 32'hFF00FF00);
    op(4'b1100, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0);
    chk("nor", ALU_result, 32'h000F000F);
    op(4'b0100, 0, 0, 32'h00000003, 0, 5'd4);
    chk("sll", ALU_result, 32'h00000030);
    op(4'b0101, 0, 0, 32'h80000000, 0, 5'd4);
    chk("srl", ALU_result, 32'h08000000);
    op(4'b1111, 0, 0, 32'h80000000, 0, 5'd4);
    chk("sra", ALU_result, 32'hF8000000);
    op(4'b0111, 0, 32'hFFFFFFFF, 32'h1, 0, 0);
    chk("slt", ALU_result, 32'h1);

    op(4'b1000, 0, 32'hFFFFFFFD, 32'd7, 0, 0);
    chk("mult_valid", {31'b0, valid_out}, 1);
    chk("mult_result", ALU_result, 0);
    chk("mult_ready", {31'b0, ready}, 0);
    wait_idle(n);
    chk("mult_cycles", n, 32);
    op(4'b1110, 0, 0, 0, 0, 0);
    chk("mult_lo", ALU_result, 32'hFFFFFFEB);
    op(4'b1101, 0, 0, 0, 0, 0);
    chk("mult_hi", ALU_result, 32'hFFFFFFFF);

    op(4'b1001, 0, 32'hFFFFFFFF, 32'd2, 0, 0);
    wait_idle(n);
    chk("multu_cycles", n, 32);
    op(4'b1101, 0, 0, 0, 0, 0);
    chk("multu_hi", ALU_result, 32'h1);
    op(4'b1110, 0, 0, 0, 0, 0);
    chk("multu_lo", ALU_result, 32'hFFFFFFFE);

    op(4'b1010, 0, 32'hFFFFFFF9, 32'd2, 0, 0);
    wait_idle(n);
    op(4'b1110, 0, 0, 0, 0, 0);
    chk("div_lo", ALU_result, 32'hFFFFFFFD);
    op(4'b1101, 0, 0, 0, 0, 0);
    chk("div_hi", ALU_result, 32'hFFFFFFFF);

    op(4'b1011, 0, 32'd7, 32'd0, 0, 0);
    wait_idle(n);
    chk("divu0_cycles", n, 32);
    op(4'b1110, 0, 0, 0, 0, 0);
    chk("divu0_lo", ALU_result, 32'hFFFFFFFF);
    op(4'b1101, 0, 0, 0, 0, 0);
    chk("divu0_hi", ALU_result, 32'd7);

    op(4'b1010, 0, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    wait_idle(n);
    op(4'b1110, 0, 0, 0, 0, 0);
    chk("ovf_lo", ALU_result, 32'h80000000);
    op(4'b1101, 0, 0, 0, 0, 0);
    chk("ovf_hi", ALU_result, 0);

    op(4'b1001, 0, 32'd5, 32'd6, 0, 0);
    ALU_control = 4'b1110; valid_in = 1;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (valid_out) break;
    end
    valid_in = 0;
    chk("stall_edges", n, 33);
    chk("stall_lo", ALU_result, 32'd30);

    op(4'b1011, 0, 32'd100, 32'd3, 0, 0);
    repeat (10) tick();
    chk("div_mid_busy", {31'b0, busy}, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_ready", {31'b0, ready}, 1);
    op(4'b1101, 0, 0, 0, 0, 0);
    chk("abort_hi", ALU_result, 0);
    op(4'b1110, 0, 0, 0, 0, 0);
    chk("abort_lo", ALU_result, 0);

    op(4'b0010, 0, 32'h11, 32'h22, 0, 0);
    chk("pre_rst_add", ALU_result, 32'h33);
    ALU_control = 4'b0010; read_data1 = 1; read_data2 = 1; valid_in = 1; reset = 1;
    tick();
    valid_in = 0; reset = 0;
    chk("rst_win_valid", {31'b0, valid_out}, 0);
    chk("rst_win_result", ALU_result, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_execute.md
Name: alu_execute

Overview:
- Execute stage of the single-issue MIPS datapath; sits directly upstream of the data memory stage.
- Selects operand B (register or sign-extended immediate), performs single-cycle ALU/shift operations, and runs multi-cycle MULT/MULTU/DIV/DIVU into internal HI/LO registers.
- Produces the registered ALU_result (memory address or writeback value), the zero flag, and the registered store data (write_data) consumed by the memory stage.
- Stalls upstream via ready while a multiply/divide is in flight.

Parameters:
- WIDTH, 32, datapath width. HI/LO, operands and results are all WIDTH bits.
- ITER, 32, iterations of the multi-cycle multiply/divide engine. Must equal WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  operation presented this cycle; accepted when valid_in && ready
- ALU_control  input  4  operation select (encoding in Behaviour)
- ALUSrc  input  1  1: operand B = sign_ext_imm; 0: operand B = read_data2
- read_data1  input  32  operand A (rs)
- read_data2  input  32  operand B register (rt); also the store data
- sign_ext_imm  input  32  sign-extended immediate
- shamt  input  5  shift amount
- ready  output  1  stage can accept an operation; equals !busy
- busy  output  1  multiply/divide engine running
- valid_out  output  1  one-cycle pulse: ALU_result/zero/write_data updated
- ALU_result  output  32  registered result, sent to memory stage
- zero  output  1  registered; 1 iff the A−B difference is 0 (all ops)
- write_data  output  32  registered copy of read_data2 at acceptance

Behaviour:
- Reset (synchronous): ALU_result=0, write_data=0, zero=0, valid_out=0, busy=0, HI=0, LO=0, counter=0, state=IDLE. Reset mid-operation aborts the engine; HI/LO are cleared.
- Encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed), 1100 NOR.
  - 0100 SLL, 0101 SRL, 1111 SRA: shift B by shamt.
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU.
  - 1101 MFHI, 1110 MFLO.
- Arithmetic rules: ADD/SUB wrap modulo 2^32 with no overflow trap. SLT gives 1 or 0 in bit 0. SRA replicates bit 31.
- Single-cycle ops:
  - Accepted at edge E → ALU_result, zero, write_data and valid_out=1 all valid after E.
  - valid_out is 0 on every cycle without an acceptance.
  - ALU_result holds its value between acceptances.
- State machine IDLE → MUL or DIV → IDLE:
  - Accept in IDLE at E0: latch operands. For signed ops, latch magnitudes plus result signs. Set busy=1 and counter=0.
  - Edges E1..E32: one shift-add or restoring-subtract iteration per edge.
  - At E32: write HI/LO, busy=0, state=IDLE. ready is high again in the cycle after E32, so busy is high for exactly 32 cycles.
  - valid_out pulses at E0 (acceptance); ALU_result = 0 for MULT/DIV ops.
- Signed correction:
  - Product negated if the operand signs differ.
  - Quotient sign = signA XOR signB.
  - Remainder takes signA.
  - −2^31 / −1 gives LO=0x80000000, HI=0.
- Divide by zero (signed or unsigned): HI = dividend (original signed value), LO = 0xFFFFFFFF, still takes 32 cycles.
- MFHI/MFLO: single-cycle; return the current HI/LO. They can only be accepted when ready=1, so a read never sees a partial result.
- valid_in while busy: ignored. The upstream stage must hold its instruction until ready.
- Simultaneous reset and valid_in: reset wins and nothing is accepted.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF, B=1 → ALU_result=0x80000000 one edge later, valid_out pulse, zero=0.
- SUB with ALUSrc=1, A=5, imm=5 → ALU_result=0, zero=1; write_data equals read_data2 at acceptance.
- MULT with A=−3, B=7 → ready low for 32 cycles. Then MFLO=0xFFFFFFEB and MFHI=0xFFFFFFFF. MULTU 0xFFFFFFFF×2 gives HI=1, LO=0xFFFFFFFE.
- DIV with A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 gives LO=0xFFFFFFFF, HI=7.
- Hold valid_in=1 with MFLO while busy → not accepted until busy falls; the returned value is the completed result.
- Assert reset at cycle 10 of a DIV → the next cycle shows busy=0, ready=1, and MFHI/MFLO return 0.
- SRA of 0x80000000 by 4 → 0xF8000000. SLT with −1 vs 1 → 1.
